// File: rtl/irq_pkg.sv
// Shared types and constants for the IM2 interrupt arbiter.
// State encoding is visible to software through the STAT register.
package irq_pkg;

    localparam int NSRC = 4;

    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_ACK  = 2'b10,
        ST_SERV = 2'b11
    } irq_state_t;

    // Bit 0 is highest priority.
    function automatic logic [1:0] lowest_idx(input logic [NSRC-1:0] v);
        lowest_idx = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one
// asynchronous interrupt source.
module irq_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_prev <= r_sync[1];
        end
    end

    assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/im2_irq_arbiter.sv
// Z80 mode-2 interrupt arbiter: edge-triggered pending bits, mask,
// INTA vector delivery and a single in-service slot released by EOI.
module im2_irq_arbiter #(
    parameter int          NSRC     = irq_pkg::NSRC,
    parameter logic [7:0]  IO_BASE  = 8'hC0,
    parameter logic [7:0]  VEC_BASE = 8'h10
) (
    input  logic            CLK50MHz,
    input  logic            RESET,
    input  logic            CPUCLK0,
    input  logic [NSRC-1:0] irq_src,
    input  logic [7:0]      A,
    input  logic [7:0]      D_in,
    input  logic            nIORQ,
    input  logic            nM1,
    input  logic            nRD,
    input  logic            nWR,
    output logic [7:0]      D_out,
    output logic            D_oe,
    output logic            int_pull
);

    import irq_pkg::*;

    irq_state_t      r_state;
    logic [7:0]      r_mask;
    logic [NSRC-1:0] r_pend;
    logic            r_int;
    logic            r_insvc_valid;
    logic [1:0]      r_insvc_idx;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_masked;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_wr_clr;
    logic [7:0]      w_off;
    logic            w_hit;
    logic            w_wr;
    logic            w_rd;
    logic            w_inta;
    logic            w_inta_stb;
    logic            w_any;
    logic            w_eoi;
    logic            w_vec_oe;
    logic [1:0]      w_win;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_edge_sync u_sync (
            .i_clk   (CLK50MHz),
            .i_rst   (RESET),
            .i_async (irq_src[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_off      = A - IO_BASE;
    assign w_hit      = (w_off[7:2] == 6'd0);
    assign w_wr       = CPUCLK0 & ~nIORQ & ~nWR & nM1 & w_hit;
    assign w_rd       = ~nIORQ & ~nRD & nM1 & w_hit;
    assign w_inta     = ~nM1 & ~nIORQ;
    assign w_inta_stb = CPUCLK0 & w_inta;
    assign w_masked   = r_pend & r_mask[NSRC-1:0];
    assign w_any      = |w_masked;
    assign w_win      = lowest_idx(w_masked);
    assign w_eoi      = w_wr & (w_off[1:0] == OFF_STAT);
    assign w_vec_oe   = (r_state == ST_ACK) & w_inta;

    always_comb begin
        w_ack_clr = '0;
        w_wr_clr  = '0;
        if (r_state == ST_REQ && w_any && w_inta_stb)
            w_ack_clr[w_win] = 1'b1;
        if (w_wr && w_off[1:0] == OFF_PEND)
            w_wr_clr = D_in[NSRC-1:0];
    end

    // New edges win over any clear landing in the same clock.
    always_ff @(posedge CLK50MHz or posedge RESET) begin
        if (RESET) begin
            r_pend <= '0;
            r_mask <= 8'h00;
        end else begin
            r_pend <= (r_pend & ~(w_ack_clr | w_wr_clr)) | w_rise;
            if (w_wr && w_off[1:0] == OFF_MASK)
                r_mask <= D_in;
        end
    end

    always_ff @(posedge CLK50MHz or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_int         <= 1'b0;
            r_insvc_valid <= 1'b0;
            r_insvc_idx   <= 2'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        r_int   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!w_any) begin
                        r_state <= ST_IDLE;
                        r_int   <= 1'b0;
                    end else if (w_inta_stb) begin
                        r_state     <= ST_ACK;
                        r_int       <= 1'b0;
                        r_insvc_idx <= w_win;
                    end
                end
                ST_ACK: begin
                    if (CPUCLK0 && nIORQ) begin
                        r_state       <= ST_SERV;
                        r_insvc_valid <= 1'b1;
                    end
                end
                ST_SERV: begin
                    if (w_eoi) begin
                        r_state       <= ST_IDLE;
                        r_insvc_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign int_pull = r_int;
    assign D_oe     = ~RESET & (w_rd | w_vec_oe);

    always_comb begin
        D_out = 8'hFF;
        if (D_oe) begin
            unique case (1'b1)
                w_vec_oe: D_out = {VEC_BASE[7:3], r_insvc_idx, 1'b0};
                w_rd: begin
                    unique case (w_off[1:0])
                        OFF_MASK: D_out = r_mask;
                        OFF_PEND: D_out = 8'(r_pend);
                        OFF_STAT: D_out = {r_state, 3'b000,
                                           r_insvc_valid, r_insvc_idx};
                        default:  D_out = 8'hFF;
                    endcase
                end
                default: D_out = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_im2_irq_arbiter.sv
// Randomized and directed bench for im2_irq_arbiter against a
// cycle-level reference model built from the register/bus rules.
module tb_im2_irq_arbiter;

    localparam logic [7:0] IO_BASE  = 8'hC0;
    localparam logic [7:0] VEC_BASE = 8'h10;

    logic       CLK50MHz = 1'b0;
    logic       RESET    = 1'b0;
    logic       CPUCLK0  = 1'b0;
    logic [3:0] irq_src  = 4'h0;
    logic [7:0] A        = 8'h00;
    logic [7:0] D_in     = 8'h00;
    logic       nIORQ    = 1'b1;
    logic       nM1      = 1'b1;
    logic       nRD      = 1'b1;
    logic       nWR      = 1'b1;
    logic [7:0] D_out;
    logic       D_oe;
    logic       int_pull;

    int n_chk = 0;
    int n_err = 0;

    im2_irq_arbiter #(
        .NSRC     (4),
        .IO_BASE  (IO_BASE),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .CLK50MHz (CLK50MHz),
        .RESET    (RESET),
        .CPUCLK0  (CPUCLK0),
        .irq_src  (irq_src),
        .A        (A),
        .D_in     (D_in),
        .nIORQ    (nIORQ),
        .nM1      (nM1),
        .nRD      (nRD),
        .nWR      (nWR),
        .D_out    (D_out),
        .D_oe     (D_oe),
        .int_pull (int_pull)
    );

    always #10 CLK50MHz = ~CLK50MHz;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. States: 0 idle, 1 requesting, 2 acked, 3 serving.
    int         m_st    = 0;
    logic [7:0] m_mask  = 8'h00;
    logic [3:0] m_pend  = 4'h0;
    logic [1:0] m_win   = 2'd0;
    logic       m_insvc = 1'b0;
    logic [3:0] m_h1 = 4'h0, m_h2 = 4'h0, m_h3 = 4'h0;
    logic [3:0] m_rise, m_masked, m_clr;
    int         m_off;
    bit         m_wr, m_inta;

    function automatic int addr_off();
        return int'(A) - int'(IO_BASE);
    endfunction

    function automatic bit addr_hit();
        int o = addr_off();
        return (o >= 0) && (o <= 3);
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] v);
        int i = 0;
        while (i < 3 && !v[i]) i++;
        return 2'(i);
    endfunction

    always @(posedge CLK50MHz or posedge RESET) begin
        if (RESET) begin
            m_st = 0; m_mask = 8'h00; m_pend = 4'h0;
            m_win = 2'd0; m_insvc = 1'b0;
            m_h1 = 4'h0; m_h2 = 4'h0; m_h3 = 4'h0;
        end else begin
            // Source high on the edge two clocks ago, low the one before.
            m_rise   = m_h2 & ~m_h3;
            m_h3     = m_h2;
            m_h2     = m_h1;
            m_h1     = irq_src;
            m_off    = addr_off();
            m_wr     = CPUCLK0 && !nIORQ && !nWR && nM1 && addr_hit();
            m_inta   = CPUCLK0 && !nM1 && !nIORQ;
            m_masked = m_pend & m_mask[3:0];
            m_clr    = 4'h0;
            if (m_wr && m_off == 1) m_clr = D_in[3:0];
            case (m_st)
                0: if (m_masked != 0) m_st = 1;
                1: begin
                    if (m_masked == 0) m_st = 0;
                    else if (m_inta) begin
                        m_win = first_set(m_masked);
                        m_clr = m_clr | (4'h1 << m_win);
                        m_st  = 2;
                    end
                end
                2: if (CPUCLK0 && nIORQ) begin m_st = 3; m_insvc = 1'b1; end
                default: if (m_wr && m_off == 2) begin
                    m_st = 0; m_insvc = 1'b0;
                end
            endcase
            if (m_wr && m_off == 0) m_mask = D_in;
            m_pend = (m_pend & ~m_clr) | m_rise;
        end
    end

    function automatic logic exp_oe();
        logic rd  = addr_hit() && !nIORQ && !nRD && nM1;
        logic vec = (m_st == 2) && !nM1 && !nIORQ;
        return !RESET && (rd || vec);
    endfunction

    function automatic logic [7:0] exp_dout();
        if (!exp_oe()) return 8'hFF;
        if (!nM1) return {VEC_BASE[7:3], m_win, 1'b0};
        case (addr_off())
            0: return m_mask;
            1: return {4'h0, m_pend};
            2: return {2'(m_st), 3'b000, m_insvc, m_win};
            default: return 8'hFF;
        endcase
    endfunction

    always @(negedge CLK50MHz) begin
        chk("int_pull", {31'd0, int_pull}, {31'd0, m_st == 1});
        chk("d_oe", {31'd0, D_oe}, {31'd0, exp_oe()});
        chk("d_out", {24'd0, D_out}, {24'd0, exp_dout()});
    end

    task automatic tick();
        @(posedge CLK50MHz);
        #2;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic io_wr(input logic [1:0] off, input logic [7:0] d);
        A = IO_BASE + 8'(off); D_in = d;
        nIORQ = 1'b0; nWR = 1'b0; CPUCLK0 = 1'b1;
        tick();
        nIORQ = 1'b1; nWR = 1'b1; CPUCLK0 = 1'b0;
    endtask

    task automatic io_rd(input logic [1:0] off, output logic [7:0] v);
        A = IO_BASE + 8'(off);
        nIORQ = 1'b0; nRD = 1'b0;
        @(negedge CLK50MHz);
        v = D_out;
        tick();
        nIORQ = 1'b1; nRD = 1'b1;
    endtask

    task automatic inta(output logic [7:0] v);
        nM1 = 1'b0; nIORQ = 1'b0; CPUCLK0 = 1'b1;
        tick();
        CPUCLK0 = 1'b0;
        @(negedge CLK50MHz);
        v = D_out;
        tick();
        nM1 = 1'b1; nIORQ = 1'b1; CPUCLK0 = 1'b1;
        tick();
        CPUCLK0 = 1'b0;
    endtask

    logic [7:0] v;

    initial begin
        #1 RESET = 1'b1;
        wait_n(3);
        chk("rst_int", {31'd0, int_pull}, 32'd0);
        chk("rst_oe", {31'd0, D_oe}, 32'd0);
        chk("rst_dout", {24'd0, D_out}, 32'hFF);
        RESET = 1'b0;
        tick();
        io_rd(2'd0, v); chk("rst_mask", {24'd0, v}, 32'h00);
        io_rd(2'd2, v); chk("rst_stat", {24'd0, v}, 32'h00);

        // Single masked-in source, vector and STAT in service.
        io_wr(2'd0, 8'h05);
        irq_src = 4'b0100; wait_n(5);
        io_rd(2'd1, v); chk("s1_pend", {24'd0, v}, 32'h04);
        chk("s1_int", {31'd0, int_pull}, 32'd1);
        inta(v); chk("s1_vec", {24'd0, v}, 32'h14);
        io_rd(2'd2, v); chk("s1_stat", {24'd0, v}, 32'hC6);
        io_wr(2'd2, 8'h00);
        irq_src = 4'b0000; wait_n(3);

        // Higher priority arriving during REQ wins at INTA.
        io_wr(2'd0, 8'h0F);
        irq_src = 4'b1000; wait_n(5);
        irq_src = 4'b1010; wait_n(5);
        inta(v); chk("s2_vec1", {24'd0, v}, 32'h12);
        io_wr(2'd2, 8'h00); wait_n(3);
        inta(v); chk("s2_vec3", {24'd0, v}, 32'h16);
        io_wr(2'd2, 8'h00);
        irq_src = 4'b0000; wait_n(3);

        // Masked source stays pending until unmasked.
        io_wr(2'd0, 8'h00);
        irq_src = 4'b0001; wait_n(5);
        io_rd(2'd1, v); chk("s3_pend", {24'd0, v}, 32'h01);
        chk("s3_int0", {31'd0, int_pull}, 32'd0);
        io_wr(2'd0, 8'h01); tick();
        chk("s3_int1", {31'd0, int_pull}, 32'd1);
        io_wr(2'd1, 8'h01); tick();
        irq_src = 4'b0000; wait_n(3);

        // PEND clear drops the request; a same-clock edge survives.
        io_wr(2'd0, 8'h0F);
        irq_src = 4'b0010; wait_n(5);
        chk("s4_int1", {31'd0, int_pull}, 32'd1);
        io_wr(2'd1, 8'h0F); tick();
        chk("s4_int0", {31'd0, int_pull}, 32'd0);
        io_rd(2'd2, v); chk("s4_idle", {30'd0, v[7:6]}, 32'd0);
        io_wr(2'd0, 8'h00);
        irq_src = 4'b0110; tick(); tick();
        io_wr(2'd1, 8'h0F);
        io_rd(2'd1, v); chk("s4_keep", {24'd0, v}, 32'h04);
        irq_src = 4'b0000; wait_n(3);
        io_wr(2'd1, 8'h0F);

        // No nesting: a new edge in service waits for EOI.
        io_wr(2'd0, 8'h01);
        irq_src = 4'b0001; wait_n(5);
        inta(v); chk("s5_vec_a", {24'd0, v}, 32'h10);
        irq_src = 4'b0000; wait_n(3);
        irq_src = 4'b0001; wait_n(5);
        chk("s5_nonest", {31'd0, int_pull}, 32'd0);
        io_wr(2'd2, 8'h00); tick();
        chk("s5_rereq", {31'd0, int_pull}, 32'd1);
        inta(v); chk("s5_vec_b", {24'd0, v}, 32'h10);
        io_wr(2'd2, 8'h00);
        irq_src = 4'b0000; wait_n(3);

        // Reset during ACK.
        irq_src = 4'b0001; wait_n(5);
        chk("s6_int", {31'd0, int_pull}, 32'd1);
        nM1 = 1'b0; nIORQ = 1'b0; CPUCLK0 = 1'b1;
        tick();
        CPUCLK0 = 1'b0;
        @(negedge CLK50MHz); #3;
        chk("s6_ack_oe", {31'd0, D_oe}, 32'd1);
        RESET = 1'b1; #1;
        chk("s6_rst_oe", {31'd0, D_oe}, 32'd0);
        chk("s6_rst_int", {31'd0, int_pull}, 32'd0);
        chk("s6_rst_dout", {24'd0, D_out}, 32'hFF);
        tick();
        RESET = 1'b0; nM1 = 1'b1; nIORQ = 1'b1; irq_src = 4'b0000;
        tick();
        io_rd(2'd0, v); chk("s6_mask", {24'd0, v}, 32'h00);
        io_rd(2'd3, v); chk("s6_unused", {24'd0, v}, 32'hFF);

        // Random traffic, checked every cycle against the model.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 6))
                0: begin irq_src = 4'($urandom); tick(); end
                1: io_wr(2'd0, 8'($urandom));
                2: io_wr(2'd1, 8'($urandom));
                3: io_wr(2'd2, 8'($urandom));
                4: io_rd(2'($urandom), v);
                5: inta(v);
                default: wait_n($urandom_range(1, 4));
            endcase
        end
        wait_n(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
